bound_flasher_param: RTL and testbench



---
 rtl/bound_flasher_param.sv | 134 +++++++++++++
 tb/tb_bound_flasher_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_param.sv
// rtl/bound_flasher_param.sv - parametrised bound flasher driving a thermometer LED bar
// Up/down bound sequence with tick prescaler, synchronised flick kickback, loop and mirror modes.
module bound_flasher_param #(
  parameter int                  N_LED   = 16,
  parameter int                  N_STEP  = 6,
  parameter logic [8*N_STEP-1:0] BOUNDS  = 48'h00_07_00_0B_05_10,
  parameter int                  KICK_HI = 5,
  parameter int                  KICK_LO = 0,
  parameter int                  PRESC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flick,
  input  logic             loop_en,
  input  logic             mirror,
  output logic [N_LED-1:0] led,
  output logic             busy,
  output logic             done,
  output logic [3:0]       step
);

  localparam int LW = $clog2(N_LED + 1);
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   lvl, lvl_nx;
  logic [3:0]      step_nx;
  logic [PW-1:0]   presc_cnt, presc_nx;
  logic            done_nx;
  logic            flick_m, flick_s;
  logic            tick, last, at_kick;
  logic [7:0]      bound, lvl8;
  logic [N_LED-1:0] bar;

  assign tick    = (presc_cnt == PW'(PRESC - 1));
  assign last    = (step == 4'(N_STEP - 1));
  assign lvl8    = 8'(lvl);
  assign bound   = 8'(BOUNDS >> {step, 3'b000});
  assign at_kick = (lvl == LW'(KICK_HI)) || (lvl == LW'(KICK_LO));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {flick_s, flick_m} <= 2'b00;
    end else begin
      {flick_s, flick_m} <= {flick_m, flick};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lvl       <= '0;
      step      <= '0;
      presc_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      lvl       <= lvl_nx;
      step      <= step_nx;
      presc_cnt <= presc_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lvl_nx   = lvl;
    step_nx  = step;
    presc_nx = presc_cnt;
    done_nx  = 1'b0;
    if (state != IDLE) begin
      presc_nx = tick ? '0 : presc_cnt + PW'(1);
    end
    case (state)
      IDLE: begin
        lvl_nx   = '0;
        step_nx  = '0;
        presc_nx = '0;
        if (flick_s) state_nx = UP;
      end
      UP: begin
        if (tick) begin
          if (lvl8 < bound) begin
            lvl_nx = lvl + LW'(1);
          end else begin
            // Even steps are never last, so reaching an UP bound always turns down.
            step_nx  = step + 4'd1;
            state_nx = DOWN;
            lvl_nx   = lvl - LW'(1);
          end
        end
      end
      DOWN: begin
        if (tick) begin
          if (flick_s && at_kick && !last) begin
            state_nx = UP;
            step_nx  = step - 4'd1;
          end else if (lvl8 > bound) begin
            lvl_nx = lvl - LW'(1);
          end else if (!last) begin
            step_nx  = step + 4'd1;
            state_nx = UP;
            lvl_nx   = lvl + LW'(1);
          end else if (loop_en) begin
            step_nx  = '0;
            state_nx = UP;
          end else begin
            state_nx = IDLE;
            lvl_nx   = '0;
            step_nx  = '0;
            presc_nx = '0;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bar = '0;
    led = '0;
    for (int i = 0; i < N_LED; i++) begin
      bar[i] = (i < int'(lvl));
    end
    for (int i = 0; i < N_LED; i++) begin
      led[i] = mirror ? bar[N_LED-1-i] : bar[i];
    end
  end

endmodule

// File: tb/tb_bound_flasher_param.sv
// tb/tb_bound_flasher_param.sv - self-checking bench for bound_flasher_param
// Two configurations checked every cycle against a step-list reference model, plus directed literals.
module tb_bound_flasher_param;

  localparam int          KH = 5;
  localparam int          KL = 0;
  localparam logic [47:0] BA = 48'h00_07_00_0B_05_10;
  localparam logic [31:0] BB = 32'h00_03_02_08;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flick_a, loop_a, mirror_a, flick_b, loop_b, mirror_b;
  logic [15:0] led_a;
  logic [7:0]  led_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [3:0]  step_a, step_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bound_flasher_param dut_a (
    .clk(clk), .rst_n(rst_n), .flick(flick_a), .loop_en(loop_a), .mirror(mirror_a),
    .led(led_a), .busy(busy_a), .done(done_a), .step(step_a)
  );

  bound_flasher_param #(.N_LED(8), .N_STEP(4), .BOUNDS(BB), .KICK_HI(KH), .KICK_LO(KL), .PRESC(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flick(flick_b), .loop_en(loop_b), .mirror(mirror_b),
    .led(led_b), .busy(busy_b), .done(done_b), .step(step_b)
  );

  typedef struct packed {
    logic       active;
    logic [7:0] step;
    logic [8:0] lvl;
    logic [7:0] cnt;
    logic       done;
    logic       s1;
    logic       s2;
  } mst_t;

  mst_t ma = '0;
  mst_t mb = '0;

  function automatic int bnd(logic [63:0] bounds, int i);
    return int'((bounds >> (8 * i)) & 64'hFF);
  endfunction

  // Direction comes from step parity: even steps climb, odd steps fall.
  function automatic mst_t mstep(mst_t s, logic fl, logic lp, int n_step, logic [63:0] bounds, int presc);
    mst_t n;
    int   st, lv, b;
    logic up, last, fs;
    n      = s;
    fs     = s.s2;
    n.s1   = fl;
    n.s2   = s.s1;
    n.done = 1'b0;
    st     = int'(s.step);
    lv     = int'(s.lvl);
    b      = bnd(bounds, st);
    up     = ((st % 2) == 0);
    last   = (st == n_step - 1);
    if (!s.active) begin
      if (fs) begin
        n.active = 1'b1;
        st = 0;
        lv = 0;
        n.cnt = '0;
      end
    end else if (int'(s.cnt) != presc - 1) begin
      n.cnt = 8'(int'(s.cnt) + 1);
    end else begin
      n.cnt = '0;
      if (!up && fs && !last && (lv == KH || lv == KL)) st = st - 1;
      else if (up && lv < b) lv = lv + 1;
      else if (!up && lv > b) lv = lv - 1;
      else if (!last) begin
        st = st + 1;
        lv = up ? lv - 1 : lv + 1;
      end else if (lp) st = 0;
      else begin
        n.active = 1'b0;
        st = 0;
        lv = 0;
        n.done = 1'b1;
      end
    end
    n.step = 8'(st);
    n.lvl  = 9'(lv);
    return n;
  endfunction

  function automatic logic [63:0] exp_led(int lvl, logic mir, int n);
    logic [63:0] v, r;
    v = (64'd1 << lvl) - 64'd1;
    r = '0;
    for (int i = 0; i < n; i++) r[n-1-i] = v[i];
    return mir ? r : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 5; i++)
      assert (bnd(64'(BA), i) != bnd(64'(BA), i + 1)) else $error("illegal bound configuration a");
    for (int i = 0; i < 3; i++)
      assert (bnd(64'(BB), i) != bnd(64'(BB), i + 1)) else $error("illegal bound configuration b");
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= mstep(ma, flick_a, loop_a, 6, 64'(BA), 1);
      mb <= mstep(mb, flick_b, loop_b, 4, 64'(BB), 4);
    end
  end

  always @(negedge clk) begin
    chk("a_led",  64'(led_a),  exp_led(int'(ma.lvl), mirror_a, 16));
    chk("a_busy", 64'(busy_a), 64'(ma.active));
    chk("a_done", 64'(done_a), 64'(ma.done));
    chk("a_step", 64'(step_a), 64'(ma.step));
    chk("b_led",  64'(led_b),  exp_led(int'(mb.lvl), mirror_b, 8));
    chk("b_busy", 64'(busy_b), 64'(mb.active));
    chk("b_done", 64'(done_b), 64'(mb.done));
    chk("b_step", 64'(step_b), 64'(mb.step));
  end

  initial begin
    int          n, changes, dn, saw4, k, tl, idle_bad;
    logic [15:0] prev, mx;
    logic [7:0]  prevb;
    logic [7:0]  vals [3];
    int          gaps [3];

    rst_n = 1'b0;
    flick_a = 1'b1; loop_a = 1'b0; mirror_a = 1'b0;
    flick_b = 1'b0; loop_b = 1'b0; mirror_b = 1'b0;
    repeat (3) cyc();
    chk("rst_led", 64'(led_a), 64'h0);
    chk("rst_busy", 64'(busy_a), 64'h0);
    flick_a = 1'b0;
    cyc();
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (20) begin
      cyc();
      if (led_a != 16'h0 || busy_a) idle_bad++;
    end
    chk("idle_hold", 64'(idle_bad), 64'h0);

    // Full default run from a one-clock flick pulse.
    flick_a = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
      if (n == 1) flick_a = 1'b0;
    end while (!busy_a && n < 10);
    chk("busy_latency", 64'(n), 64'd3);
    prev = led_a; changes = 0; dn = 0; mx = 16'h0; n = 0;
    do begin
      cyc();
      n++;
      if (led_a != prev) changes++;
      prev = led_a;
      if (done_a) dn++;
      if (led_a > mx) mx = led_a;
    end while (busy_a && n < 300);
    chk("run_level_changes", 64'(changes), 64'd58);
    chk("run_done_pulses", 64'(dn), 64'd1);
    chk("run_peak", 64'(mx), 64'hFFFF);
    chk("run_end_led", 64'(led_a), 64'h0);
    cyc();
    chk("run_done_clear", 64'(done_a), 64'h0);

    // Kickback at the upper level during step 1.
    flick_a = 1'b1; cyc(); flick_a = 1'b0;
    n = 0;
    while (step_a != 4'd1 && n < 100) begin cyc(); n++; end
    chk("kick_hi_reach_step1", 64'(n < 100), 64'h1);
    flick_a = 1'b1;
    n = 0;
    while (step_a != 4'd0 && n < 100) begin cyc(); n++; end
    chk("kick_hi_back", 64'(n < 100), 64'h1);
    chk("kick_hi_lvl", 64'(led_a), 64'h001F);
    chk("kick_hi_busy", 64'(busy_a), 64'h1);
    flick_a = 1'b0;
    cyc();
    chk("kick_hi_climb", 64'(led_a), 64'h003F);
    n = 0;
    while (busy_a && n < 300) begin cyc(); n++; end
    chk("kick_hi_finish", 64'(n < 300), 64'h1);

    // Kickback at the lower level in step 3; none on the last step.
    flick_a = 1'b1; cyc(); flick_a = 1'b0;
    n = 0;
    while (!(step_a == 4'd3 && led_a == 16'h0003) && n < 200) begin cyc(); n++; end
    flick_a = 1'b1; cyc(); flick_a = 1'b0;
    n = 0;
    while (step_a != 4'd2 && n < 10) begin cyc(); n++; end
    chk("kick_lo_back", 64'(n < 10), 64'h1);
    chk("kick_lo_lvl", 64'(led_a), 64'h0);
    n = 0;
    while (step_a != 4'd3 && n < 30) begin cyc(); n++; end
    chk("kick_lo_reclimb", 64'(led_a), 64'h03FF);
    n = 0;
    while (!(step_a == 4'd5 && led_a == 16'h0003) && n < 200) begin cyc(); n++; end
    flick_a = 1'b1; cyc(); flick_a = 1'b0;
    saw4 = 0; dn = 0; n = 0;
    do begin
      cyc();
      n++;
      if (step_a == 4'd4) saw4++;
      if (done_a) dn++;
    end while (busy_a && n < 20);
    chk("last_no_kick", 64'(saw4), 64'h0);
    chk("last_done", 64'(dn), 64'd1);
    repeat (5) cyc();
    chk("last_stays_idle", 64'(busy_a), 64'h0);

    // Asynchronous reset mid-run, flick held through reset.
    flick_a = 1'b1; cyc(); flick_a = 1'b0;
    n = 0;
    while (!(busy_a && step_a == 4'd0 && led_a == 16'h01FF) && n < 50) begin cyc(); n++; end
    chk("reset_reach_lvl9", 64'(n < 50), 64'h1);
    #2;
    rst_n = 1'b0;
    flick_a = 1'b1;
    #1;
    chk("async_led", 64'(led_a), 64'h0);
    chk("async_busy", 64'(busy_a), 64'h0);
    chk("async_step", 64'(step_a), 64'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    n = 0;
    while (!busy_a && n < 10) begin cyc(); n++; end
    chk("reset_restart", 64'(n < 10), 64'h1);
    flick_a = 1'b0;
    n = 0;
    while (busy_a && n < 300) begin cyc(); n++; end

    // Prescaler, mirror and loop on the 8-LED instance.
    mirror_b = 1'b1; loop_b = 1'b1;
    flick_b = 1'b1; cyc(); flick_b = 1'b0;
    n = 0;
    while (!busy_b && n < 10) begin cyc(); n++; end
    prevb = led_b; k = 0; n = 0; tl = 0;
    while (k < 3 && n < 100) begin
      cyc();
      n++;
      if (led_b != prevb) begin
        vals[k] = led_b;
        gaps[k] = n - tl;
        tl = n;
        k++;
      end
      prevb = led_b;
    end
    chk("presc_seen", 64'(k), 64'd3);
    chk("mirror_v0", 64'(vals[0]), 64'h80);
    chk("mirror_v1", 64'(vals[1]), 64'hC0);
    chk("mirror_v2", 64'(vals[2]), 64'hE0);
    chk("presc_gap0", 64'(gaps[0]), 64'd4);
    chk("presc_gap1", 64'(gaps[1]), 64'd4);
    chk("presc_gap2", 64'(gaps[2]), 64'd4);
    dn = 0; n = 0;
    while (step_b != 4'd3 && n < 400) begin cyc(); n++; if (done_b) dn++; end
    n = 0;
    while (step_b != 4'd0 && n < 400) begin cyc(); n++; if (done_b) dn++; end
    chk("loop_wrapped", 64'(n < 400), 64'h1);
    chk("loop_no_done", 64'(dn), 64'h0);
    chk("loop_busy", 64'(busy_b), 64'h1);
    chk("loop_lvl", 64'(led_b), 64'h0);
    loop_b = 1'b0;
    dn = 0; n = 0;
    while (busy_b && n < 400) begin cyc(); n++; end
    if (done_b) dn++;
    chk("loop_off_done", 64'(dn), 64'd1);

    // Randomised traffic on both instances against the model.
    repeat (3000) begin
      cyc();
      if ($urandom_range(0, 15) == 0) flick_a = ~flick_a;
      if ($urandom_range(0, 15) == 0) flick_b = ~flick_b;
      if ($urandom_range(0, 63) == 0) loop_a = ~loop_a;
      if ($urandom_range(0, 63) == 0) loop_b = ~loop_b;
      if ($urandom_range(0, 31) == 0) mirror_a = ~mirror_a;
      if ($urandom_range(0, 31) == 0) mirror_b = ~mirror_b;
    end
    flick_a = 1'b0; flick_b = 1'b0;
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
